// File: rtl/hk_spi_regs.sv
`timescale 1ns/1ps
// hk_spi_regs: housekeeping SPI slave (mode 0) exposing chip ID bytes and PLL/IRQ/ext-reset controls.
// Latency: SPI pins are seen 2 clocks late through synchronizers; a written byte is visible 1 clock after its 8th bit.
// Backpressure: none; the host paces every transfer with sck, and csb high aborts the frame.
module hk_spi_regs #(
    parameter logic [11:0] MFG_ID     = 12'h456,
    parameter logic [7:0]  PRODUCT_ID = 8'h11,
    parameter logic [31:0] PROJECT_ID = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sck,
    input  logic        csb,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_oe,
    input  logic        trap,
    output logic        pll_ena,
    output logic        pll_dco_ena,
    output logic        pll_bypass,
    output logic        irq,
    output logic        reset_ext,
    output logic [25:0] pll_trim,
    output logic [2:0]  pll_sel,
    output logic [2:0]  pll90_sel,
    output logic [4:0]  pll_div
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        ADDR = 2'd2,
        DATA = 2'd3
    } state_t;

    state_t      state, state_nxt;

    logic        sck_m, sck_s, sck_d;
    logic        csb_m, csb_s, csb_d;
    logic        sdi_m, sdi_s;

    logic        sck_rise, csb_fall, bit_tick, byte_done;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [7:0]  byte_in;
    logic [7:0]  addr;
    logic [7:0]  out_sr;
    logic        rd_en, wr_en;
    logic [7:0]  rd_addr, rd_dat;
    logic        reg_wr;

    logic [1:0]  reg08;
    logic        reg09, reg0a, reg0b;
    logic [7:0]  reg0d, reg0e, reg0f;
    logic [1:0]  reg10;
    logic [5:0]  reg11;
    logic [4:0]  reg12;

    // csb chain resets low so a frame already in progress at reset release
    // never looks like a fresh falling edge; it must see csb high first.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_m <= 1'b0; sck_s <= 1'b0; sck_d <= 1'b0;
            csb_m <= 1'b0; csb_s <= 1'b0; csb_d <= 1'b0;
            sdi_m <= 1'b0; sdi_s <= 1'b0;
        end else begin
            sck_m <= sck;  sck_s <= sck_m; sck_d <= sck_s;
            csb_m <= csb;  csb_s <= csb_m; csb_d <= csb_s;
            sdi_m <= sdi;  sdi_s <= sdi_m;
        end
    end

    assign sck_rise  = sck_s & ~sck_d;
    assign csb_fall  = csb_d & ~csb_s;
    assign bit_tick  = sck_rise & ~csb_s & (state != IDLE);
    assign byte_done = bit_tick & (bit_cnt == 3'd7);
    assign byte_in   = {shift_in, sdi_s};
    assign reg_wr    = byte_done & wr_en & (state == DATA);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (csb_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (csb_fall)  state_nxt = CMD;
                CMD:     if (byte_done) state_nxt = ADDR;
                ADDR:    if (byte_done) state_nxt = DATA;
                DATA:    state_nxt = DATA;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // An unknown command leaves both rd_en and wr_en clear, so the rest of
    // the frame walks the FSM without ever driving sdo or touching a register.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            shift_in <= 7'd0;
            addr     <= 8'd0;
            out_sr   <= 8'd0;
            rd_en    <= 1'b0;
            wr_en    <= 1'b0;
        end else if (csb_s) begin
            bit_cnt <= 3'd0;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
        end else if (state == IDLE) begin
            bit_cnt <= 3'd0;
        end else if (bit_tick) begin
            shift_in <= byte_in[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            case (state)
                CMD: begin
                    if (byte_done) begin
                        rd_en <= (byte_in == 8'h40) || (byte_in == 8'hc0);
                        wr_en <= (byte_in == 8'h80) || (byte_in == 8'hc0);
                    end
                end
                ADDR: begin
                    if (byte_done) begin
                        addr <= byte_in;
                        if (rd_en) out_sr <= rd_dat;
                    end
                end
                DATA: begin
                    if (byte_done) begin
                        addr <= addr + 8'd1;
                        if (rd_en) out_sr <= rd_dat;
                    end else begin
                        out_sr <= {out_sr[6:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign sdo_oe = (state == DATA) & rd_en;
    assign sdo    = sdo_oe & out_sr[7];

    // Only one lookup is needed per clock: the just-received address while in
    // ADDR, otherwise the byte after the current one for streaming.
    assign rd_addr = (state == ADDR) ? byte_in : addr + 8'd1;

    always_comb begin
        rd_dat = 8'h00;
        case (rd_addr)
            8'h01:   rd_dat = {4'b0, MFG_ID[11:8]};
            8'h02:   rd_dat = MFG_ID[7:0];
            8'h03:   rd_dat = PRODUCT_ID;
            8'h04:   rd_dat = PROJECT_ID[31:24];
            8'h05:   rd_dat = PROJECT_ID[23:16];
            8'h06:   rd_dat = PROJECT_ID[15:8];
            8'h07:   rd_dat = PROJECT_ID[7:0];
            8'h08:   rd_dat = {6'b0, reg08};
            8'h09:   rd_dat = {7'b0, reg09};
            8'h0a:   rd_dat = {7'b0, reg0a};
            8'h0b:   rd_dat = {7'b0, reg0b};
            8'h0c:   rd_dat = {7'b0, trap};
            8'h0d:   rd_dat = reg0d;
            8'h0e:   rd_dat = reg0e;
            8'h0f:   rd_dat = reg0f;
            8'h10:   rd_dat = {6'b0, reg10};
            8'h11:   rd_dat = {2'b0, reg11};
            8'h12:   rd_dat = {3'b0, reg12};
            default: rd_dat = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reg08 <= 2'b10;
            reg09 <= 1'b1;
            reg0a <= 1'b0;
            reg0b <= 1'b0;
            reg0d <= 8'hff;
            reg0e <= 8'hef;
            reg0f <= 8'hff;
            reg10 <= 2'b11;
            reg11 <= 6'h12;
            reg12 <= 5'h04;
        end else if (reg_wr) begin
            case (addr)
                8'h08:   reg08 <= byte_in[1:0];
                8'h09:   reg09 <= byte_in[0];
                8'h0a:   reg0a <= byte_in[0];
                8'h0b:   reg0b <= byte_in[0];
                8'h0d:   reg0d <= byte_in;
                8'h0e:   reg0e <= byte_in;
                8'h0f:   reg0f <= byte_in;
                8'h10:   reg10 <= byte_in[1:0];
                8'h11:   reg11 <= byte_in[5:0];
                8'h12:   reg12 <= byte_in[4:0];
                default: ;
            endcase
        end
    end

    assign pll_ena     = reg08[0];
    assign pll_dco_ena = reg08[1];
    assign pll_bypass  = reg09;
    assign irq         = reg0a;
    assign reset_ext   = reg0b;
    assign pll_trim    = {reg10, reg0f, reg0e, reg0d};
    assign pll_sel     = reg11[2:0];
    assign pll90_sel   = reg11[5:3];
    assign pll_div     = reg12;

endmodule

// File: tb/tb_hk_spi_regs.sv
`timescale 1ns/1ps
// Bench for hk_spi_regs: a mode-0 SPI host drives frames, expected read bytes are
// queued at issue time and a monitor rebuilds bytes from sdo and scores them.
module tb_hk_spi_regs;

    localparam int HALF = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sck = 1'b0;
    logic        csb = 1'b1;
    logic        sdi = 1'b0;
    logic        trap = 1'b0;
    logic        sdo, sdo_oe;
    logic        pll_ena, pll_dco_ena, pll_bypass, irq, reset_ext;
    logic [25:0] pll_trim;
    logic [2:0]  pll_sel, pll90_sel;
    logic [4:0]  pll_div;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q [$];

    logic [7:0] map_exp [0:18] = '{8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00,
                                   8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hff,
                                   8'hef, 8'hff, 8'h03, 8'h12, 8'h04};

    hk_spi_regs dut (
        .clock(clock), .reset(reset), .sck(sck), .csb(csb), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .trap(trap),
        .pll_ena(pll_ena), .pll_dco_ena(pll_dco_ena), .pll_bypass(pll_bypass),
        .irq(irq), .reset_ext(reset_ext), .pll_trim(pll_trim),
        .pll_sel(pll_sel), .pll90_sel(pll90_sel), .pll_div(pll_div)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic spi_bit(input logic b);
        sdi = b;
        tick(HALF);
        sck = 1'b1;
        tick(HALF);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic frame_start();
        csb = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_end();
        tick(HALF);
        csb = 1'b1;
        tick(12);
    endtask

    task automatic spi_read(input logic [7:0] a, input int n);
        frame_start();
        spi_byte(8'h40);
        spi_byte(a);
        for (int i = 0; i < n; i++) spi_byte(8'h00);
        frame_end();
    endtask

    task automatic spi_write1(input logic [7:0] a, input logic [7:0] d);
        frame_start();
        spi_byte(8'h80);
        spi_byte(a);
        spi_byte(d);
        frame_end();
    endtask

    task automatic check_defaults(input string tag);
        check({tag, "_sdo_oe"}, {31'b0, sdo_oe}, 32'd0);
        check({tag, "_sdo"}, {31'b0, sdo}, 32'd0);
        check({tag, "_pll_ena"}, {31'b0, pll_ena}, 32'd0);
        check({tag, "_pll_dco_ena"}, {31'b0, pll_dco_ena}, 32'd1);
        check({tag, "_pll_bypass"}, {31'b0, pll_bypass}, 32'd1);
        check({tag, "_irq"}, {31'b0, irq}, 32'd0);
        check({tag, "_reset_ext"}, {31'b0, reset_ext}, 32'd0);
        check({tag, "_pll_trim"}, {6'b0, pll_trim}, 32'h3ffefff);
        check({tag, "_pll_sel"}, {29'b0, pll_sel}, 32'd2);
        check({tag, "_pll90_sel"}, {29'b0, pll90_sel}, 32'd2);
        check({tag, "_pll_div"}, {27'b0, pll_div}, 32'd4);
    endtask

    // Monitor: sdo is sampled at each host sck rise while the DUT drives it.
    initial begin : monitor
        logic [7:0] sh;
        logic [7:0] e;
        int nb;
        sh = 8'h00;
        nb = 0;
        forever begin
            @(posedge sck or posedge csb);
            if (csb) begin
                nb = 0;
            end else if (sdo_oe) begin
                sh = {sh[6:0], sdo};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL rd_unexpected: got 0x%02h with no byte expected", sh);
                    end else begin
                        e = exp_q.pop_front();
                        if (sh !== e) begin
                            failures++;
                            $display("FAIL rd_byte: got 0x%02h expected 0x%02h", sh, e);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        tick(10);
        reset = 1'b0;
        tick(4);
        check_defaults("rst");

        exp_q.push_back(8'h11);
        spi_read(8'h03, 1);

        for (int i = 0; i < 19; i++) exp_q.push_back(map_exp[i]);
        spi_read(8'h00, 19);

        spi_write1(8'h0b, 8'h01);
        check("reset_ext_set", {31'b0, reset_ext}, 32'd1);
        spi_write1(8'h0b, 8'h00);
        check("reset_ext_clr", {31'b0, reset_ext}, 32'd0);
        exp_q.push_back(8'h00);
        spi_read(8'h0b, 1);

        frame_start();
        spi_byte(8'h80);
        spi_byte(8'h0d);
        spi_byte(8'h12);
        spi_byte(8'h34);
        spi_byte(8'h56);
        spi_byte(8'h01);
        frame_end();
        check("pll_trim_wr", {6'b0, pll_trim}, 32'h1563412);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h56);
        exp_q.push_back(8'h01);
        spi_read(8'h0d, 4);
        spi_write1(8'h03, 8'haa);
        exp_q.push_back(8'h11);
        spi_read(8'h03, 1);

        frame_start();
        spi_byte(8'h80);
        spi_byte(8'h0a);
        spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b1);
        frame_end();
        check("irq_partial", {31'b0, irq}, 32'd0);
        spi_write1(8'h0a, 8'h01);
        check("irq_set", {31'b0, irq}, 32'd1);
        trap = 1'b1;
        exp_q.push_back(8'h01);
        spi_read(8'h0c, 1);

        spi_write1(8'h08, 8'h01);
        check("pll_ena_wr", {30'b0, pll_dco_ena, pll_ena}, 32'd1);

        frame_start();
        spi_byte(8'h80);
        spi_bit(1'b0); spi_bit(1'b0); spi_bit(1'b0); spi_bit(1'b0);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check_defaults("midrst");
        spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1);
        spi_byte(8'h01);
        check("midrst_oe_after", {31'b0, sdo_oe}, 32'd0);
        frame_end();
        check("midrst_reset_ext", {31'b0, reset_ext}, 32'd0);

        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h04);
        spi_read(8'hff, 3);

        tick(20);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hk_spi_regs.md
Name: hk_spi_regs

Overview:
- Housekeeping SPI slave with register file for the vsdcaravel management area.
- An external host on mprj_io[4:1] (sck, csb, sdi, sdo) reads chip identification and reads/writes PLL, IRQ and external-reset control bits.
- All SPI pins are oversampled in the single system clock domain; there are no SCK-clocked flops.

Parameters:
- MFG_ID, 12'h456, manufacturer ID; reg1 = {4'b0, MFG_ID[11:8]}, reg2 = MFG_ID[7:0].
- PRODUCT_ID, 8'h11, product ID; reg3.
- PROJECT_ID, 32'h0, user project ID; reg4..reg7 = bytes [31:24]..[7:0].

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sck  in  1  SPI clock (mode 0), asynchronous to clock.
- csb  in  1  SPI chip select, active low.
- sdi  in  1  SPI serial data in.
- sdo  out  1  SPI serial data out.
- sdo_oe  out  1  high while a read data byte is being shifted out.
- trap  in  1  CPU trap status, readable at reg 0x0c.
- pll_ena  out  1  reg8[0].
- pll_dco_ena  out  1  reg8[1].
- pll_bypass  out  1  reg9[0].
- irq  out  1  reg 0x0a[0].
- reset_ext  out  1  reg 0x0b[0]; external reset request.
- pll_trim  out  26  reg 0x0d=[7:0], 0x0e=[15:8], 0x0f=[23:16], 0x10[1:0]=[25:24].
- pll_sel  out  3  reg 0x11[2:0].
- pll90_sel  out  3  reg 0x11[5:3].
- pll_div  out  5  reg 0x12[4:0].

Behaviour:
- Input sync: sck, csb and sdi each pass through a 2-FF synchronizer. SCK edges are detected from the synchronized value. SCK high/low phases are at least 4 clocks.
- Reset values:
  - reg8 = 0x02 (pll_dco_ena=1, pll_ena=0).
  - reg9 = 0x01; 0x0a = 0x00; 0x0b = 0x00.
  - 0x0d = 0xff, 0x0e = 0xef, 0x0f = 0xff, 0x10 = 0x03 (pll_trim = 26'h3ffefff).
  - 0x11 = 0x12 (pll_sel=2, pll90_sel=2); 0x12 = 0x04.
  - sdo=0, sdo_oe=0, FSM in IDLE.
- Read map:
  - 0x00 = 0x00 (status).
  - 0x01..0x07 are ID bytes per the parameters.
  - 0x0c = {7'b0, trap}.
  - Writable registers read back their stored value; unimplemented bits read 0.
  - Addresses 0x13..0xff read 0x00.
- Writes: only 0x08..0x0b and 0x0d..0x12 are writable; writes elsewhere are ignored.
- FSM states: IDLE -> CMD -> ADDR -> DATA.
  - csb high (synchronized) forces IDLE from any state within 3 clocks. A partial byte is discarded.
  - csb falling: enter CMD, clear the bit counter.
  - Bits are sampled MSB-first on each detected SCK rising edge.
  - After 8 bits, CMD latches the command: 0x40 = read stream, 0x80 = write stream, 0xC0 = read+write stream. Any other value is ignored until csb rises; sdo stays 0.
  - After 8 bits, ADDR latches the 8-bit address and moves to DATA.
- Read out:
  - On entering DATA with a read command, load mem[addr] into the output shifter and drive bit 7 on sdo with sdo_oe=1.
  - After each subsequent SCK rise, shift so the next bit is on sdo within 4 clocks.
  - The host samples sdo just before the next rising edge.
  - Once 8 bits have been clocked, load mem[addr+1] for the next byte.
- Write: when the 8th data bit is sampled, commit the byte to mem[addr] (output visible next clock), then increment addr.
- Read+write: the old value is shifted out while the new value is committed.
- Address is 8-bit and wraps 0xff -> 0x00.
- Reset asserted mid-transaction returns to IDLE and restores defaults. Traffic on the same csb-low frame is ignored until csb rises.

Test Plan:
- Reset 10 cycles, release; frame 0x40, 0x03, read 1 byte -> 0x11.
- Stream read from addr 0x00, 19 bytes -> 00 04 56 11 00 00 00 00 02 01 00 00 00 ff ef ff 03 12 04.
- Write 0x80, 0x0b, 0x01 -> reset_ext=1; write 0x80, 0x0b, 0x00 -> reset_ext=0; readback 0x0b = 0x00.
- Write 0x80, 0x0d, then bytes 0x12 0x34 0x56 0x01 -> pll_trim = 26'h1563412; stream read 0x0d..0x10 returns same; write to reg 0x03 -> still reads 0x11.
- Raise csb after 4 bits of a write data byte -> register unchanged; next frame works normally; with trap=1, reg 0x0c reads 0x01.
- Assert reset during an ADDR byte -> outputs return to defaults, sdo_oe=0; read 0xff then continue streaming -> 0x00 then wraps to addr 0x00 (0x00), 0x01 (0x04).
